// File: rtl/instr_prefetch_unit.sv
`default_nettype none
// ============================================================================
// Module : instr_prefetch_unit
// Credit-limited sequential instruction prefetcher feeding an async FIFO,
// with in-order local buffering and redirect flush.
// Rev    : 1.0
// ============================================================================
module instr_prefetch_unit #(
  parameter int                DATA_SIZE  = 32,
  parameter int                ADDR_W     = 11,
  parameter int                BUF_DEPTH  = 4,
  parameter logic [ADDR_W-1:0] RESET_ADDR = '0
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 enable,
  input  logic                 branch_valid,
  input  logic [ADDR_W-1:0]    branch_address,
  output logic                 mem_r_en,
  output logic [ADDR_W-1:0]    mem_r_adrs,
  input  logic                 mem_r_valid,
  input  logic [DATA_SIZE-1:0] mem_data,
  input  logic                 fifo_full,
  output logic                 fifo_w_en,
  output logic [DATA_SIZE-1:0] fifo_w_data,
  output logic                 fifo_flush,
  output logic [ADDR_W-1:0]    fetch_pc,
  output logic                 proto_err
);

  localparam int c_PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int c_CNT_W = $clog2(BUF_DEPTH + 1);
  localparam logic [c_CNT_W:0]   c_CREDIT_MAX = (c_CNT_W + 1)'(BUF_DEPTH);
  localparam logic [c_PTR_W-1:0] c_PTR_LAST   = c_PTR_W'(BUF_DEPTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t               r_state;
  logic [ADDR_W-1:0]    r_pc;
  logic [c_CNT_W-1:0]   r_outstanding;
  logic [c_CNT_W-1:0]   r_buf_count;
  logic [c_PTR_W-1:0]   r_wr_ptr;
  logic [c_PTR_W-1:0]   r_rd_ptr;
  logic [DATA_SIZE-1:0] r_buf [BUF_DEPTH];
  logic                 r_mem_r_en;
  logic [ADDR_W-1:0]    r_mem_r_adrs;
  logic                 r_fifo_flush;
  logic                 r_proto_err;

  logic [c_CNT_W:0]     w_credit_sum;
  logic                 w_resp_ok;
  logic                 w_spurious;
  logic                 w_issue;
  logic                 w_buf_wr;
  logic                 w_pop;
  logic [c_CNT_W-1:0]   w_out_dec;

  function automatic logic [c_PTR_W-1:0] f_ptr_inc(input logic [c_PTR_W-1:0] p);
    return (p == c_PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  // Outstanding reads plus buffered words never exceed BUF_DEPTH, so a
  // returning word always has a free slot.
  assign w_credit_sum = {1'b0, r_outstanding} + {1'b0, r_buf_count};
  assign w_resp_ok    = mem_r_valid && (r_outstanding != '0);
  assign w_spurious   = mem_r_valid && (r_outstanding == '0);
  assign w_issue      = (r_state == ST_FETCH) && enable && !branch_valid &&
                        (w_credit_sum < c_CREDIT_MAX);
  assign w_buf_wr     = (r_state == ST_FETCH) && !branch_valid && w_resp_ok;
  assign w_pop        = (r_state == ST_FETCH) && (r_buf_count != '0) && !fifo_full;
  assign w_out_dec    = r_outstanding - c_CNT_W'(w_resp_ok);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state       <= ST_IDLE;
      r_pc          <= RESET_ADDR;
      r_outstanding <= '0;
      r_buf_count   <= '0;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_mem_r_en    <= 1'b0;
      r_mem_r_adrs  <= '0;
      r_fifo_flush  <= 1'b0;
      r_proto_err   <= 1'b0;
    end else begin
      r_mem_r_en   <= 1'b0;
      r_fifo_flush <= 1'b0;
      if (w_spurious) begin
        r_proto_err <= 1'b1;
      end
      case (r_state)
        ST_IDLE: begin
          if (branch_valid) begin
            r_pc <= branch_address;
          end
          if (enable) begin
            r_state <= ST_FETCH;
          end
        end
        ST_FETCH, ST_DRAIN: begin
          if (branch_valid) begin
            // Any response landing this cycle belongs to the old stream.
            r_pc          <= branch_address;
            r_fifo_flush  <= 1'b1;
            r_buf_count   <= '0;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_outstanding <= w_out_dec;
            r_state       <= (w_out_dec != '0) ? ST_DRAIN : ST_FETCH;
          end else if (r_state == ST_DRAIN) begin
            r_outstanding <= w_out_dec;
            if (w_out_dec == '0) begin
              r_state <= ST_FETCH;
            end
          end else begin
            if (w_issue) begin
              r_mem_r_en   <= 1'b1;
              r_mem_r_adrs <= r_pc;
              r_pc         <= r_pc + 1'b1;
            end
            r_outstanding <= r_outstanding + c_CNT_W'(w_issue) - c_CNT_W'(w_resp_ok);
            r_buf_count   <= r_buf_count + c_CNT_W'(w_buf_wr) - c_CNT_W'(w_pop);
            if (w_buf_wr) begin
              r_wr_ptr <= f_ptr_inc(r_wr_ptr);
            end
            if (w_pop) begin
              r_rd_ptr <= f_ptr_inc(r_rd_ptr);
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_buf_wr) begin
      r_buf[r_wr_ptr] <= mem_data;
    end
  end

  assign mem_r_en    = r_mem_r_en;
  assign mem_r_adrs  = r_mem_r_adrs;
  assign fifo_w_en   = w_pop;
  assign fifo_w_data = r_buf[r_rd_ptr];
  assign fifo_flush  = r_fifo_flush;
  assign fetch_pc    = r_pc;
  assign proto_err   = r_proto_err;

endmodule
`default_nettype wire
